// File: rtl/upg_loader.sv
// UART-programming loader: parses framed load commands from a received byte
// stream and issues single-cycle word writes into instruction or data memory.
module upg_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        upg_clk_i,
    input  logic        upg_rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        upg_wen_o,
    output logic [14:0] upg_addr_o,
    output logic [31:0] upg_data_o,
    output logic        upg_done_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] TGT  = 3'd1;
    localparam logic [2:0] CLO  = 3'd2;
    localparam logic [2:0] CHI  = 3'd3;
    localparam logic [2:0] DATA = 3'd4;
    localparam logic [2:0] CSUM = 3'd5;
    localparam logic [2:0] DONE = 3'd6;

    localparam logic [7:0]  SYNC_BYTE    = 8'hA5;
    localparam logic [15:0] MAX_COUNT    = 16'd16384;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state_q,     state_d;
    logic        target_q,    target_d;
    logic [7:0]  countLo_q,   countLo_d;
    logic [14:0] remaining_q, remaining_d;
    logic [13:0] wordIdx_q,   wordIdx_d;
    logic [1:0]  lane_q,      lane_d;
    logic [7:0]  xor_q,       xor_d;
    logic [23:0] shift_q,     shift_d;
    logic [31:0] timer_q,     timer_d;
    logic        wen_q,       wen_d;
    logic [14:0] addr_q,      addr_d;
    logic [31:0] data_q,      data_d;
    logic        done_q,      done_d;
    logic        err_q,       err_d;

    logic [15:0] count;
    logic        active;

    assign count  = {rx_data_i, countLo_q};
    assign active = (state_q == TGT) || (state_q == CLO) || (state_q == CHI) ||
                    (state_q == DATA) || (state_q == CSUM);

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        countLo_d   = countLo_q;
        remaining_d = remaining_q;
        wordIdx_d   = wordIdx_q;
        lane_d      = lane_q;
        xor_d       = xor_q;
        shift_d     = shift_q;
        timer_d     = 32'd0;
        wen_d       = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = done_q;
        err_d       = err_q;

        // An inter-byte gap that runs out abandons the frame; a byte arriving
        // in the same cycle always wins over the timeout.
        if (active && !rx_valid_i) begin
            if (timer_q == TIMEOUT_LAST) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                timer_d = timer_q + 32'd1;
            end
        end

        if (rx_valid_i) begin
            case (state_q)
                IDLE: begin
                    if (rx_data_i == SYNC_BYTE) begin
                        state_d = TGT;
                        err_d   = 1'b0;
                    end
                end
                TGT: begin
                    case (rx_data_i)
                        8'h00: begin
                            target_d = 1'b0;
                            state_d  = CLO;
                        end
                        8'h01: begin
                            target_d = 1'b1;
                            state_d  = CLO;
                        end
                        8'hFF: begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end
                CLO: begin
                    countLo_d = rx_data_i;
                    state_d   = CHI;
                end
                CHI: begin
                    if (count == 16'd0 || count > MAX_COUNT) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        remaining_d = count[14:0];
                        wordIdx_d   = 14'd0;
                        lane_d      = 2'd0;
                        xor_d       = 8'd0;
                        state_d     = DATA;
                    end
                end
                DATA: begin
                    xor_d  = xor_q ^ rx_data_i;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: shift_d[7:0]   = rx_data_i;
                        2'd1: shift_d[15:8]  = rx_data_i;
                        2'd2: shift_d[23:16] = rx_data_i;
                        default: begin
                            wen_d       = 1'b1;
                            addr_d      = {target_q, wordIdx_q};
                            data_d      = {rx_data_i, shift_q};
                            wordIdx_d   = wordIdx_q + 14'd1;
                            remaining_d = remaining_q - 15'd1;
                            if (remaining_q == 15'd1) begin
                                state_d = CSUM;
                            end
                        end
                    endcase
                end
                CSUM: begin
                    if (rx_data_i != xor_q) begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
        if (upg_rst_i) begin
            state_q     <= IDLE;
            target_q    <= 1'b0;
            countLo_q   <= 8'd0;
            remaining_q <= 15'd0;
            wordIdx_q   <= 14'd0;
            lane_q      <= 2'd0;
            xor_q       <= 8'd0;
            shift_q     <= 24'd0;
            timer_q     <= 32'd0;
            wen_q       <= 1'b0;
            addr_q      <= 15'd0;
            data_q      <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            countLo_q   <= countLo_d;
            remaining_q <= remaining_d;
            wordIdx_q   <= wordIdx_d;
            lane_q      <= lane_d;
            xor_q       <= xor_d;
            shift_q     <= shift_d;
            timer_q     <= timer_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign upg_wen_o  = wen_q;
    assign upg_addr_o = addr_q;
    assign upg_data_o = data_q;
    assign upg_done_o = done_q;
    assign busy_o     = active;
    assign err_o      = err_q;

endmodule

// File: tb/tb_upg_loader.sv
// Self-checking bench for upg_loader: frames are built from word lists, the
// expected writes are queued at issue time and a negedge monitor checks them.
module tb_upg_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        upgWen;
    logic [14:0] upgAddr;
    logic [31:0] upgData;
    logic        upgDone;
    logic        busy;
    logic        err;

    int checkCount = 0;
    int errorCount = 0;

    logic [14:0] expAddr[$];
    logic [31:0] expData[$];
    logic [31:0] frameWords[$];

    upg_loader #(.TIMEOUT_CYCLES(16)) dut (
        .upg_clk_i (clk),
        .upg_rst_i (rst),
        .rx_data_i (rxData),
        .rx_valid_i(rxValid),
        .upg_wen_o (upgWen),
        .upg_addr_o(upgAddr),
        .upg_data_o(upgData),
        .upg_done_o(upgDone),
        .busy_o    (busy),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One byte per call; the strobe is sampled by the next rising edge.
    task automatic applyStimulus(input logic [7:0] b);
        rxData  = b;
        rxValid = 1'b1;
        @(posedge clk);
        #1;
        rxValid = 1'b0;
    endtask

    // Reference model: a good frame writes word i of the list to index i of
    // the selected memory; a corrupt checksum keeps the writes but flags err.
    task automatic sendFrame(input logic [7:0] tgt, input bit corrupt, input int gapMax);
        logic [7:0]  csum;
        logic [31:0] w;
        logic [15:0] n;
        csum = 8'd0;
        n    = 16'(frameWords.size());
        for (int i = 0; i < frameWords.size(); i++) begin
            w    = frameWords[i];
            csum = csum ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            expAddr.push_back({tgt[0], 14'(i)});
            expData.push_back(w);
        end
        applyStimulus(8'hA5);
        applyStimulus(tgt);
        applyStimulus(n[7:0]);
        applyStimulus(n[15:8]);
        for (int i = 0; i < frameWords.size(); i++) begin
            w = frameWords[i];
            for (int b = 0; b < 4; b++) begin
                if (gapMax > 0) idleCycles($urandom_range(gapMax, 0));
                applyStimulus(w[8*b +: 8]);
            end
        end
        applyStimulus(corrupt ? (csum ^ 8'h5A) : csum);
    endtask

    always @(negedge clk) begin
        if (upgWen) begin
            if (expAddr.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL unexpected_write: got addr %0h data %0h required no write",
                         upgAddr, upgData);
            end else begin
                checkOutput("write_addr", {17'd0, upgAddr}, {17'd0, expAddr.pop_front()});
                checkOutput("write_data", upgData, expData.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b0;
        rxData  = 8'd0;
        rxValid = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_wen", {31'd0, upgWen}, 32'd0);
        checkOutput("reset_addr", {17'd0, upgAddr}, 32'd0);
        checkOutput("reset_data", upgData, 32'd0);
        checkOutput("reset_done", {31'd0, upgDone}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        idleCycles(2);

        $display("[TB] IMem load");
        frameWords = '{32'h12345678, 32'hDEADBEEF};
        sendFrame(8'h00, 1'b0, 0);
        idleCycles(2);
        checkOutput("imem_err", {31'd0, err}, 32'd0);
        checkOutput("imem_busy", {31'd0, busy}, 32'd0);

        $display("[TB] bytes outside a frame");
        applyStimulus(8'h3C);
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        checkOutput("idle_ignore_busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_ignore_done", {31'd0, upgDone}, 32'd0);

        $display("[TB] bad checksum");
        frameWords = '{32'h12345678, 32'hDEADBEEF};
        expAddr.push_back(15'h0000);
        expData.push_back(32'h12345678);
        expAddr.push_back(15'h0001);
        expData.push_back(32'hDEADBEEF);
        applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h02); applyStimulus(8'h00);
        applyStimulus(8'h78); applyStimulus(8'h56); applyStimulus(8'h34); applyStimulus(8'h12);
        applyStimulus(8'hEF); applyStimulus(8'hBE); applyStimulus(8'hAD); applyStimulus(8'hDE);
        applyStimulus(8'h55);
        checkOutput("csum_err", {31'd0, err}, 32'd1);
        applyStimulus(8'hA5);
        checkOutput("sync_clears_err", {31'd0, err}, 32'd0);

        $display("[TB] bad headers");
        applyStimulus(8'h07);
        checkOutput("bad_target_err", {31'd0, err}, 32'd1);
        checkOutput("bad_target_busy", {31'd0, busy}, 32'd0);
        applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        checkOutput("count0_err", {31'd0, err}, 32'd1);
        checkOutput("count0_busy", {31'd0, busy}, 32'd0);
        applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h01); applyStimulus(8'h40);
        checkOutput("count16385_err", {31'd0, err}, 32'd1);
        checkOutput("count16385_busy", {31'd0, busy}, 32'd0);

        $display("[TB] timeout");
        applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h01); applyStimulus(8'h00);
        applyStimulus(8'h11); applyStimulus(8'h22);
        idleCycles(14);
        checkOutput("timeout_not_early", {31'd0, busy}, 32'd1);
        idleCycles(6);
        checkOutput("timeout_err", {31'd0, err}, 32'd1);
        checkOutput("timeout_busy", {31'd0, busy}, 32'd0);
        frameWords = '{32'hCAFEF00D};
        sendFrame(8'h00, 1'b0, 0);
        idleCycles(1);
        checkOutput("after_timeout_err", {31'd0, err}, 32'd0);

        $display("[TB] random frames");
        for (int f = 0; f < 30; f++) begin
            logic [7:0] tgt;
            bit         bad;
            int         nw;
            tgt = 8'($urandom_range(1, 0));
            bad = ($urandom_range(3, 0) == 0);
            nw  = $urandom_range(4, 1);
            frameWords.delete();
            for (int i = 0; i < nw; i++) frameWords.push_back($urandom);
            sendFrame(tgt, bad, 3);
            idleCycles($urandom_range(2, 1));
            checkOutput("random_err", {31'd0, err}, {31'd0, bad});
        end

        $display("[TB] reset mid-frame");
        applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h01); applyStimulus(8'h00);
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
        checkOutput("midframe_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_addr", {17'd0, upgAddr}, 32'd0);
        checkOutput("midreset_data", upgData, 32'd0);
        checkOutput("midreset_err", {31'd0, err}, 32'd0);
        #1;
        applyStimulus(8'h44);
        idleCycles(1);
        rst = 1'b0;
        idleCycles(2);
        frameWords = '{32'h0BADC0DE, 32'h76543210};
        sendFrame(8'h01, 1'b0, 1);
        idleCycles(1);
        checkOutput("after_reset_err", {31'd0, err}, 32'd0);

        $display("[TB] DMem back-to-back and finish");
        expAddr.push_back(15'h4000);
        expData.push_back(32'h04030201);
        applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h01); applyStimulus(8'h00);
        applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03);
        applyStimulus(8'h04);
        checkOutput("dmem_wen_timing", {31'd0, upgWen}, 32'd1);
        applyStimulus(8'h04);
        checkOutput("dmem_err", {31'd0, err}, 32'd0);
        applyStimulus(8'hA5);
        applyStimulus(8'hFF);
        checkOutput("finish_done", {31'd0, upgDone}, 32'd1);
        checkOutput("finish_busy", {31'd0, busy}, 32'd0);
        applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h01); applyStimulus(8'h00);
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h44);
        applyStimulus(8'h44);
        idleCycles(3);
        checkOutput("done_sticky", {31'd0, upgDone}, 32'd1);
        checkOutput("done_ignore_busy", {31'd0, busy}, 32'd0);
        checkOutput("scoreboard_empty", 32'(expAddr.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
